atacante_automatico: RTL and testbench

// - Automatic opponent: the initiator side of the attack interface. It drives the column/row/confirm inputs
//   of the attack manager in ATAQUE mode, in place of switches ch5..ch0 and btn0.
// - Consumes the hit/miss verdict. Hunt sweep over the 5x7 grid plus neighbour targeting after a hit.
// - Never fires twice at the same cell.

---
 rtl/atacante_automatico.sv | 163 ++++++++++++++++
 tb/tb_atacante_automatico.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/atacante_automatico.sv
// Automatic attacker: hunt sweep plus neighbour targeting, one confirmar pulse per shot, never repeats a cell.
// Shot cadence: INTERVALO idle cycles, one cycle per evaluated candidate, then wait for verdict or TIMEOUT.
`timescale 1ns/1ps
module atacante_automatico #(
    parameter int COLUNAS   = 5,
    parameter int LINHAS    = 7,
    parameter int INTERVALO = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       tem_vida,
    input  logic       resp_valida,
    input  logic       resp_acerto,
    output logic [2:0] coordColuna,
    output logic [2:0] coordLinha,
    output logic       confirmar,
    output logic       ocupado,
    output logic       fim,
    output logic [5:0] tiros
);

    localparam int CELLS = COLUNAS * LINHAS;
    localparam int CMAX  = (INTERVALO > TIMEOUT) ? INTERVALO : TIMEOUT;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        OCIOSO, ESPERA, ESCOLHE, DISPARA, AGUARDA, FIM
    } estado_t;

    estado_t          r_estado;
    estado_t          w_prox;
    logic [CW-1:0]    r_cnt;
    logic [CELLS-1:0] r_mapa;
    logic [2:0]       r_varre_col;
    logic [2:0]       r_varre_lin;
    logic [3:0]       r_mascara;
    logic [2:0]       r_acerto_col;
    logic [2:0]       r_acerto_lin;
    logic [2:0]       r_col;
    logic [2:0]       r_lin;
    logic [5:0]       r_tiros;

    logic             w_ativo;
    logic             w_mapa_cheio;
    logic [3:0]       w_viz_um;
    logic [2:0]       w_cand_col;
    logic [2:0]       w_cand_lin;
    logic             w_cand_dentro;
    logic [5:0]       w_cand_idx;
    logic             w_cand_livre;
    logic [5:0]       w_tiro_idx;

    assign w_ativo      = enable & tem_vida;
    assign w_mapa_cheio = &r_mapa;
    assign w_tiro_idx   = {3'b000, r_col} * 6'(LINHAS) + {3'b000, r_lin};

    // Candidate for this ESCOLHE cycle: lowest pending neighbour bit (N,S,W,E) or else the sweep pointer.
    always_comb begin
        w_viz_um      = r_mascara & (~r_mascara + 4'd1);
        w_cand_col    = r_varre_col;
        w_cand_lin    = r_varre_lin;
        w_cand_dentro = 1'b1;
        if (r_mascara != 4'd0) begin
            w_cand_col = r_acerto_col;
            w_cand_lin = r_acerto_lin;
            if (w_viz_um[0]) begin
                w_cand_lin    = r_acerto_lin - 3'd1;
                w_cand_dentro = (r_acerto_lin != 3'd0);
            end else if (w_viz_um[1]) begin
                w_cand_lin    = r_acerto_lin + 3'd1;
                w_cand_dentro = (r_acerto_lin < 3'(LINHAS - 1));
            end else if (w_viz_um[2]) begin
                w_cand_col    = r_acerto_col - 3'd1;
                w_cand_dentro = (r_acerto_col != 3'd0);
            end else begin
                w_cand_col    = r_acerto_col + 3'd1;
                w_cand_dentro = (r_acerto_col < 3'(COLUNAS - 1));
            end
        end
        w_cand_idx   = w_cand_dentro ? ({3'b000, w_cand_col} * 6'(LINHAS) + {3'b000, w_cand_lin}) : 6'd0;
        w_cand_livre = w_cand_dentro && !r_mapa[w_cand_idx];
    end

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:  if (w_ativo) w_prox = ESPERA;
            ESPERA:  if (r_cnt <= CW'(1)) w_prox = ESCOLHE;
            ESCOLHE: begin
                if (w_mapa_cheio)      w_prox = FIM;
                else if (w_cand_livre) w_prox = DISPARA;
            end
            DISPARA: w_prox = AGUARDA;
            AGUARDA: if (resp_valida || r_cnt <= CW'(1)) w_prox = OCIOSO;
            FIM:     w_prox = FIM;
            default: w_prox = OCIOSO;
        endcase
        if (!w_ativo && r_estado != FIM) w_prox = OCIOSO;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_estado     <= OCIOSO;
            r_cnt        <= '0;
            r_mapa       <= '0;
            r_varre_col  <= 3'd0;
            r_varre_lin  <= 3'd0;
            r_mascara    <= 4'd0;
            r_acerto_col <= 3'd0;
            r_acerto_lin <= 3'd0;
            r_col        <= 3'd0;
            r_lin        <= 3'd0;
            r_tiros      <= 6'd0;
        end else begin
            r_estado <= w_prox;
            case (r_estado)
                OCIOSO: if (w_ativo) r_cnt <= CW'(INTERVALO);
                ESPERA: if (w_ativo) r_cnt <= r_cnt - CW'(1);
                // Candidate is consumed only while active so a pause never loses an unshot sweep cell.
                ESCOLHE: begin
                    if (w_ativo && !w_mapa_cheio) begin
                        if (r_mascara != 4'd0) begin
                            r_mascara <= r_mascara & ~w_viz_um;
                        end else if (r_varre_lin == 3'(LINHAS - 1)) begin
                            r_varre_lin <= 3'd0;
                            r_varre_col <= (r_varre_col == 3'(COLUNAS - 1)) ? 3'd0 : r_varre_col + 3'd1;
                        end else begin
                            r_varre_lin <= r_varre_lin + 3'd1;
                        end
                        if (w_cand_livre) begin
                            r_col <= w_cand_col;
                            r_lin <= w_cand_lin;
                        end
                    end
                end
                DISPARA: begin
                    r_mapa[w_tiro_idx] <= 1'b1;
                    if (r_tiros != 6'(CELLS)) r_tiros <= r_tiros + 6'd1;
                    r_cnt <= CW'(TIMEOUT);
                end
                AGUARDA: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (w_ativo && resp_valida && resp_acerto) begin
                        r_mascara    <= 4'b1111;
                        r_acerto_col <= r_col;
                        r_acerto_lin <= r_lin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign coordColuna = r_col;
    assign coordLinha  = r_lin;
    assign confirmar   = (r_estado == DISPARA);
    assign ocupado     = (r_estado == DISPARA) || (r_estado == AGUARDA);
    assign fim         = (r_estado == FIM);
    assign tiros       = r_tiros;

endmodule

// File: tb/tb_atacante_automatico.sv
// Bench for atacante_automatico: directed pause/reset steps plus randomized verdicts against a grid model.
`timescale 1ns/1ps
module tb_atacante_automatico;

    localparam int C  = 5;
    localparam int L  = 7;
    localparam int IV = 4;
    localparam int TO = 16;
    localparam int N  = C * L;

    logic       clock_in    = 1'b0;
    logic       reset_n     = 1'b0;
    logic       enable      = 1'b0;
    logic       tem_vida    = 1'b0;
    logic       resp_valida = 1'b0;
    logic       resp_acerto = 1'b0;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic       confirmar;
    logic       ocupado;
    logic       fim;
    logic [5:0] tiros;

    atacante_automatico #(.COLUNAS(C), .LINHAS(L), .INTERVALO(IV), .TIMEOUT(TO)) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .enable      (enable),
        .tem_vida    (tem_vida),
        .resp_valida (resp_valida),
        .resp_acerto (resp_acerto),
        .coordColuna (coordColuna),
        .coordLinha  (coordLinha),
        .confirmar   (confirmar),
        .ocupado     (ocupado),
        .fim         (fim),
        .tiros       (tiros)
    );

    always #5 clock_in = ~clock_in;

    int ciclo = 0;
    always @(posedge clock_in) ciclo++;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: shot grid indexed col*L+lin, sweep index, pending neighbour list of last hit.
    bit m_shot[N];
    int m_sweep;
    bit m_pend[4];
    int m_hc, m_hl;
    int m_tiros;
    bit m_done;
    int last_fire, last_d;
    bit force23;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    function automatic void model_reset();
        foreach (m_shot[i]) m_shot[i] = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_sweep = 0; m_hc = 0; m_hl = 0; m_tiros = 0; m_done = 1'b0;
    endfunction

    function automatic void model_pick(output bit done, output int c, output int l, output int ev);
        int  k, nc, nl, idx;
        bit  all;
        done = 1'b0; c = 0; l = 0; ev = 0;
        while (1) begin
            all = 1'b1;
            foreach (m_shot[i]) if (!m_shot[i]) all = 1'b0;
            if (all) begin
                done = 1'b1;
                return;
            end
            if (m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3]) begin
                k = 0;
                while (!m_pend[k]) k++;
                m_pend[k] = 1'b0;
                ev++;
                nc = m_hc + ((k == 2) ? -1 : (k == 3) ? 1 : 0);
                nl = m_hl + ((k == 0) ? -1 : (k == 1) ? 1 : 0);
                if (nc >= 0 && nc < C && nl >= 0 && nl < L && !m_shot[nc*L+nl]) begin
                    c = nc; l = nl;
                    return;
                end
            end else begin
                idx = m_sweep;
                m_sweep = (m_sweep + 1) % N;
                ev++;
                if (!m_shot[idx]) begin
                    c = idx / L; l = idx % L;
                    return;
                end
            end
        end
    endfunction

    // d>0: verdict in AGUARDA cycle d (d>=TO means no verdict); d==0: drop enable; d<0: reset pulse.
    task automatic do_shot(input int d, input bit hit_in, input bit check_gap);
        bit done, seen, hit;
        int c, l, ev, cnt;
        model_pick(done, c, l, ev);
        if (done) begin
            m_done = 1'b1;
            return;
        end
        hit = hit_in || (force23 && c == 2 && l == 3);
        seen = 1'b0;
        for (int w = 0; w < 300 && !seen; w++) begin
            tick();
            if (confirmar) seen = 1'b1;
        end
        chk("confirmar_seen", seen, 1);
        if (!seen) return;
        chk("coluna", coordColuna, c);
        chk("linha", coordLinha, l);
        if (check_gap) chk("gap", ciclo - last_fire, 6 + last_d + ev);
        last_fire = ciclo;
        m_shot[c*L+l] = 1'b1;
        if (m_tiros < N) m_tiros++;
        tick();
        chk("tiros", tiros, m_tiros);
        chk("ocupado_aguarda", ocupado, 1);
        chk("confirmar_pulso", confirmar, 0);
        if (d < 0) begin
            reset_n = 1'b0;
            #1;
            chk("rst_confirmar", confirmar, 0);
            chk("rst_ocupado", ocupado, 0);
            chk("rst_tiros", tiros, 0);
            chk("rst_coluna", coordColuna, 0);
            chk("rst_linha", coordLinha, 0);
            chk("rst_fim", fim, 0);
            tick();
            reset_n = 1'b1;
            model_reset();
        end else if (d == 0) begin
            enable = 1'b0;
            tick();
            chk("pausa_ocupado", ocupado, 0);
            cnt = 0;
            repeat (20) begin
                tick();
                if (confirmar) cnt++;
            end
            chk("pausa_sem_tiro", cnt, 0);
            chk("pausa_tiros", tiros, m_tiros);
            enable = 1'b1;
        end else if (d >= TO) begin
            repeat (TO - 1) tick();
            chk("timeout_ocupado_alto", ocupado, 1);
            tick();
            chk("timeout_ocupado_baixo", ocupado, 0);
            last_d = TO;
        end else begin
            repeat (d - 1) tick();
            resp_valida = 1'b1;
            resp_acerto = hit;
            tick();
            resp_valida = 1'b0;
            resp_acerto = 1'b0;
            chk("veredito_ocupado", ocupado, 0);
            last_d = d;
            if (hit) begin
                foreach (m_pend[i]) m_pend[i] = 1'b1;
                m_hc = c; m_hl = l;
            end
        end
    endtask

    initial begin
        int cnt, dd, r;
        bit seen;
        model_reset();
        last_fire = 0; last_d = 0; force23 = 1'b0;
        tick();
        tick();
        chk("reset_coluna", coordColuna, 0);
        chk("reset_linha", coordLinha, 0);
        chk("reset_confirmar", confirmar, 0);
        chk("reset_ocupado", ocupado, 0);
        chk("reset_fim", fim, 0);
        chk("reset_tiros", tiros, 0);
        reset_n = 1'b1;
        enable = 1'b1;
        tem_vida = 1'b1;

        // Misses one cycle into AGUARDA, then pause in AGUARDA of the 3rd shot; 4th shot must be (0,3).
        do_shot(1, 1'b0, 1'b0);
        do_shot(1, 1'b0, 1'b1);
        do_shot(0, 1'b0, 1'b1);
        do_shot(1, 1'b0, 1'b0);
        do_shot(2, 1'b0, 1'b1);

        // tem_vida low mid-interval: nothing fires until it returns.
        tick();
        tick();
        tem_vida = 1'b0;
        cnt = 0;
        repeat (20) begin
            tick();
            if (confirmar) cnt++;
        end
        chk("sem_vida_sem_tiro", cnt, 0);
        tem_vida = 1'b1;
        do_shot(TO, 1'b0, 1'b0);
        do_shot(-1, 1'b0, 1'b0);

        // Fresh game: corner hit, then randomized verdicts to the end with (2,3) always a hit.
        do_shot(1, 1'b1, 1'b0);
        chk("canto_n_vizinho_s", coordLinha, 0);
        do_shot(1, 1'b0, 1'b1);
        chk("canto_s_linha", coordLinha, 1);
        do_shot(1, 1'b0, 1'b1);
        chk("canto_e_coluna", coordColuna, 1);
        force23 = 1'b1;
        for (int i = 0; i < 60 && !m_done; i++) begin
            r  = int'($urandom_range(0, 9));
            dd = (r == 0) ? TO : 1 + int'($urandom_range(0, 3));
            do_shot(dd, ($urandom_range(0, 3) == 0), 1'b1);
        end
        chk("modelo_terminou", m_done, 1);

        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
            tick();
            if (fim) seen = 1'b1;
        end
        chk("fim_alto", fim, 1);
        chk("fim_tiros", tiros, N);
        cnt = 0;
        repeat (30) begin
            tick();
            if (confirmar) cnt++;
        end
        chk("fim_sem_tiro", cnt, 0);
        chk("fim_mantido", fim, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
